// File: rtl/spi_slave_param_if.sv
// Bus bundle for spi_slave_param: SPI pins, RAM read-back handshake and status strobes.
interface spi_slave_param_if #(
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned FRAME_W = DATA_W + 2;

   logic               SS_n;
   logic               MOSI;
   logic               tx_valid;
   logic [DATA_W-1:0]  tx_data;
   logic               rx_valid;
   logic [FRAME_W-1:0] rx_data;
   logic               MISO;
   logic               busy;
   logic               timeout_err;
   logic               par_err;

   modport slave (
      input  SS_n, MOSI, tx_valid, tx_data,
      output rx_valid, rx_data, MISO, busy, timeout_err, par_err
   );

   modport master (
      output SS_n, MOSI, tx_valid, tx_data,
      input  rx_valid, rx_data, MISO, busy, timeout_err, par_err
   );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises cmd+payload frames, serialises RAM read data on MISO.
// Define SPI_SLAVE_PARITY_EN to append a trailing odd-parity bit to every MOSI frame.
module spi_slave_param #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned MISO_MSB_FIRST = 1,
   parameter int unsigned TX_TIMEOUT     = 16
) (
   input logic              clk,
   input logic              reset,
   spi_slave_param_if.slave bus
);
   localparam int unsigned FrameW = DATA_W + 2;
   localparam int unsigned BitW   = $clog2(FrameW + 2);
   localparam int unsigned ToW    = $clog2(TX_TIMEOUT + 1);
`ifdef SPI_SLAVE_PARITY_EN
   localparam int unsigned LastCnt = FrameW;
`else
   localparam int unsigned LastCnt = FrameW - 1;
`endif
   // Shift register holds every bit seen before the final edge of the frame.
   localparam int unsigned ShW = LastCnt;

   typedef enum logic [2:0] {StIdle, StRx, StReadWait, StTx, StDone} state_e;

   state_e              state_q, state_d;
   logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [ToW-1:0]      to_cnt_q, to_cnt_d;
   logic [ShW-1:0]      rx_sh_q, rx_sh_d;
   logic [FrameW-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
   logic                miso_q, miso_d;
   logic                timeout_err_q, timeout_err_d;
`ifdef SPI_SLAVE_PARITY_EN
   logic                par_err_q, par_err_d;
`endif

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      to_cnt_d      = to_cnt_q;
      rx_sh_d       = rx_sh_q;
      rx_data_d     = rx_data_q;
      tx_sh_d       = tx_sh_q;
      miso_d        = miso_q;
      rx_valid_d    = 1'b0;
      timeout_err_d = 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_err_d     = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (!bus.SS_n) begin
               rx_sh_d   = {rx_sh_q[ShW-2:0], bus.MOSI};
               bit_cnt_d = BitW'(1);
               state_d   = StRx;
            end
         end
         StRx: begin
            if (bus.SS_n) begin
               state_d = StIdle;
            end else begin
               rx_sh_d   = {rx_sh_q[ShW-2:0], bus.MOSI};
               bit_cnt_d = bit_cnt_q + BitW'(1);
               if (bit_cnt_q == BitW'(LastCnt)) begin
`ifdef SPI_SLAVE_PARITY_EN
                  if (^{rx_sh_q, bus.MOSI}) begin
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
                     state_d    = (rx_sh_q[ShW-1 -: 2] == 2'b11) ? StReadWait : StDone;
                  end else begin
                     par_err_d = 1'b1;
                     state_d   = StDone;
                  end
`else
                  rx_data_d  = {rx_sh_q, bus.MOSI};
                  rx_valid_d = 1'b1;
                  state_d    = (rx_sh_q[ShW-1 -: 2] == 2'b11) ? StReadWait : StDone;
`endif
               end
            end
         end
         StReadWait: begin
            if (bus.SS_n) begin
               state_d = StIdle;
            end else if (bus.tx_valid) begin
               // First output bit goes out on the accepting edge itself.
               miso_d    = (MISO_MSB_FIRST != 0) ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
               tx_sh_d   = (MISO_MSB_FIRST != 0) ? (bus.tx_data << 1) : (bus.tx_data >> 1);
               bit_cnt_d = BitW'(1);
               to_cnt_d  = '0;
               state_d   = StTx;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
               if (to_cnt_q == ToW'(TX_TIMEOUT - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = StDone;
               end
            end
         end
         StTx: begin
            if (bus.SS_n) begin
               state_d = StIdle;
            end else if (bit_cnt_q == BitW'(DATA_W)) begin
               miso_d  = 1'b0;
               state_d = StDone;
            end else begin
               miso_d    = (MISO_MSB_FIRST != 0) ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
               tx_sh_d   = (MISO_MSB_FIRST != 0) ? (tx_sh_q << 1) : (tx_sh_q >> 1);
               bit_cnt_d = bit_cnt_q + BitW'(1);
            end
         end
         StDone: begin
            miso_d = 1'b0;
            if (bus.SS_n) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Entering IDLE (abort or frame end) always clears counters and MISO.
      if (state_d == StIdle) begin
         bit_cnt_d = '0;
         to_cnt_d  = '0;
         miso_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         bit_cnt_q     <= '0;
         to_cnt_q      <= '0;
         rx_sh_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_sh_q       <= '0;
         miso_q        <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
         par_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         to_cnt_q      <= to_cnt_d;
         rx_sh_q       <= rx_sh_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_sh_q       <= tx_sh_d;
         miso_q        <= miso_d;
         timeout_err_q <= timeout_err_d;
`ifdef SPI_SLAVE_PARITY_EN
         par_err_q     <= par_err_d;
`endif
      end
   end

   assign bus.rx_valid    = rx_valid_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.MISO        = miso_q;
   assign bus.busy        = (state_q != StIdle);
   assign bus.timeout_err = timeout_err_q;
`ifdef SPI_SLAVE_PARITY_EN
   assign bus.par_err     = par_err_q;
`else
   assign bus.par_err     = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: one MSB-first and one LSB-first instance share stimulus.
module tb_spi_slave_param;
   localparam int unsigned DW = 8;
   localparam int unsigned FW = DW + 2;
`ifdef SPI_SLAVE_PARITY_EN
   localparam int unsigned NB = FW;
`else
   localparam int unsigned NB = FW - 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          ss_n;
   logic          mosi;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   int            tests = 0;
   int            fails = 0;

   spi_slave_param_if #(.DATA_W(DW)) bus_m ();
   spi_slave_param_if #(.DATA_W(DW)) bus_l ();

   assign bus_m.SS_n = ss_n;
   assign bus_m.MOSI = mosi;
   assign bus_m.tx_valid = tx_valid;
   assign bus_m.tx_data = tx_data;
   assign bus_l.SS_n = ss_n;
   assign bus_l.MOSI = mosi;
   assign bus_l.tx_valid = tx_valid;
   assign bus_l.tx_data = tx_data;

   spi_slave_param #(.DATA_W(DW), .MISO_MSB_FIRST(1), .TX_TIMEOUT(16)) dut_m (
      .clk(clk), .reset(reset), .bus(bus_m)
   );
   spi_slave_param #(.DATA_W(DW), .MISO_MSB_FIRST(0), .TX_TIMEOUT(16)) dut_l (
      .clk(clk), .reset(reset), .bus(bus_l)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [FW-1:0] frame);
      for (int i = FW - 1; i >= 0; i--) begin
         ss_n = 1'b0;
         mosi = frame[i];
         tick();
      end
   endtask

   task automatic send_frame(input logic [FW-1:0] frame);
      send_bits(frame);
`ifdef SPI_SLAVE_PARITY_EN
      mosi = ~(^frame);
      tick();
`endif
   endtask

   task automatic end_frame();
      ss_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      tick(); tick();
      reset = 1'b0;
      tests++; if (bus_m.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", bus_m.rx_valid); end
      tests++; if (bus_m.rx_data !== 10'h000) begin fails++; $display("FAIL reset_rx_data: got %h want 000", bus_m.rx_data); end
      tests++; if ({bus_m.MISO, bus_l.MISO} !== 2'b00) begin fails++; $display("FAIL reset_miso: got %b want 00", {bus_m.MISO, bus_l.MISO}); end
      tests++; if (bus_m.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus_m.busy); end
      tests++; if ({bus_m.timeout_err, bus_m.par_err} !== 2'b00) begin fails++; $display("FAIL reset_errs: got %b want 00", {bus_m.timeout_err, bus_m.par_err}); end
   endtask

   task automatic test_write_addr();
      tx_valid = 1'b1; tx_data = 8'h55;  // ignored outside READ_WAIT
      send_frame(10'b00_1010_0101);
      tests++; if (bus_m.rx_valid !== 1'b1) begin fails++; $display("FAIL wr_rx_valid: got %b want 1", bus_m.rx_valid); end
      tests++; if (bus_m.rx_data !== 10'h0A5) begin fails++; $display("FAIL wr_rx_data: got %h want 0a5", bus_m.rx_data); end
      mosi = 1'b1;
      tick();
      tests++; if (bus_m.rx_valid !== 1'b0) begin fails++; $display("FAIL wr_rx_valid_pulse: got %b want 0", bus_m.rx_valid); end
      tests++; if ({bus_m.busy, bus_m.MISO} !== 2'b10) begin fails++; $display("FAIL wr_done_busy_miso: got %b want 10", {bus_m.busy, bus_m.MISO}); end
      end_frame();
      tests++; if (bus_m.busy !== 1'b0) begin fails++; $display("FAIL wr_busy_clear: got %b want 0", bus_m.busy); end
      tx_valid = 1'b0;
   endtask

   task automatic test_read(input logic [DW-1:0] data, input logic early);
      if (early) begin
         tx_valid = 1'b1; tx_data = data;
      end
      send_frame(10'h300);
      tests++; if ({bus_m.rx_valid, bus_m.rx_data} !== {1'b1, 10'h300}) begin fails++; $display("FAIL rd_frame: got %b_%h want 1_300", bus_m.rx_valid, bus_m.rx_data); end
      tests++; if ({bus_m.MISO, bus_l.MISO} !== 2'b00) begin fails++; $display("FAIL rd_entry_miso: got %b want 00", {bus_m.MISO, bus_l.MISO}); end
      if (!early) begin
         tick();
         tests++; if ({bus_m.busy, bus_m.MISO} !== 2'b10) begin fails++; $display("FAIL rd_wait: got %b want 10", {bus_m.busy, bus_m.MISO}); end
         tx_valid = 1'b1; tx_data = data;
      end
      tick();
      tx_valid = 1'b0; tx_data = ~data;  // must not affect the bits already captured
      for (int i = 0; i < DW; i++) begin
         tests++; if (bus_m.MISO !== data[DW-1-i]) begin fails++; $display("FAIL rd_msb_bit%0d: got %b want %b", i, bus_m.MISO, data[DW-1-i]); end
         tests++; if (bus_l.MISO !== data[i]) begin fails++; $display("FAIL rd_lsb_bit%0d: got %b want %b", i, bus_l.MISO, data[i]); end
         tick();
      end
      tests++; if ({bus_m.MISO, bus_l.MISO, bus_m.busy} !== 3'b001) begin fails++; $display("FAIL rd_tail: got %b want 001", {bus_m.MISO, bus_l.MISO, bus_m.busy}); end
      end_frame();
      tests++; if (bus_m.busy !== 1'b0) begin fails++; $display("FAIL rd_busy_clear: got %b want 0", bus_m.busy); end
   endtask

   task automatic test_timeout();
      int early_pulses = 0;
      tx_valid = 1'b0;
      send_frame(10'h300);
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus_m.timeout_err !== 1'b0 || bus_m.busy !== 1'b1) early_pulses++;
      end
      tests++; if (early_pulses !== 0) begin fails++; $display("FAIL to_early: got %0d bad cycles want 0", early_pulses); end
      tick();
      tests++; if ({bus_m.timeout_err, bus_m.busy, bus_m.MISO} !== 3'b110) begin fails++; $display("FAIL to_pulse: got %b want 110", {bus_m.timeout_err, bus_m.busy, bus_m.MISO}); end
      tx_valid = 1'b1; tx_data = 8'hFF;
      tick();
      tests++; if ({bus_m.timeout_err, bus_m.MISO} !== 2'b00) begin fails++; $display("FAIL to_after: got %b want 00", {bus_m.timeout_err, bus_m.MISO}); end
      tx_valid = 1'b0;
      end_frame();
      tests++; if (bus_m.busy !== 1'b0) begin fails++; $display("FAIL to_idle: got %b want 0", bus_m.busy); end
      send_frame(10'b01_1111_0000);
      tests++; if ({bus_m.rx_valid, bus_m.rx_data} !== {1'b1, 10'h1F0}) begin fails++; $display("FAIL to_next_frame: got %b_%h want 1_1f0", bus_m.rx_valid, bus_m.rx_data); end
      end_frame();
   endtask

   task automatic test_abort();
      logic [FW-1:0] f = 10'b10_1100_1100;
      for (int i = FW - 1; i > FW - 6; i--) begin
         ss_n = 1'b0; mosi = f[i]; tick();
      end
      end_frame();
      tests++; if ({bus_m.busy, bus_m.rx_valid} !== 2'b00) begin fails++; $display("FAIL ab5_state: got %b want 00", {bus_m.busy, bus_m.rx_valid}); end
      tests++; if (bus_m.rx_data !== 10'h1F0) begin fails++; $display("FAIL ab5_rx_data: got %h want 1f0", bus_m.rx_data); end
      // Abort coinciding with the final frame edge.
      for (int i = 0; i < NB; i++) begin
         ss_n = 1'b0; mosi = 1'b1; tick();
      end
      ss_n = 1'b1; mosi = 1'b1;
      tick();
      tests++; if ({bus_m.busy, bus_m.rx_valid, bus_m.par_err} !== 3'b000) begin fails++; $display("FAIL ab_last_state: got %b want 000", {bus_m.busy, bus_m.rx_valid, bus_m.par_err}); end
      tests++; if (bus_m.rx_data !== 10'h1F0) begin fails++; $display("FAIL ab_last_rx_data: got %h want 1f0", bus_m.rx_data); end
      send_frame(10'h23C);
      tests++; if ({bus_m.rx_valid, bus_m.rx_data} !== {1'b1, 10'h23C}) begin fails++; $display("FAIL ab_next_frame: got %b_%h want 1_23c", bus_m.rx_valid, bus_m.rx_data); end
      end_frame();
   endtask

   task automatic test_reset_mid_tx();
      send_frame(10'h300);
      tx_valid = 1'b1; tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0;
      tests++; if ({bus_m.MISO, bus_l.MISO, bus_m.busy} !== 3'b111) begin fails++; $display("FAIL rst_tx_start: got %b want 111", {bus_m.MISO, bus_l.MISO, bus_m.busy}); end
      tick();
      reset = 1'b1;
      tick();
      tests++; if ({bus_m.MISO, bus_l.MISO, bus_m.busy} !== 3'b000) begin fails++; $display("FAIL rst_tx_idle: got %b want 000", {bus_m.MISO, bus_l.MISO, bus_m.busy}); end
      tests++; if (bus_m.rx_data !== 10'h000) begin fails++; $display("FAIL rst_tx_rx_data: got %h want 000", bus_m.rx_data); end
      ss_n = 1'b1; reset = 1'b0;
      tick();
   endtask

`ifdef SPI_SLAVE_PARITY_EN
   task automatic test_parity();
      send_bits(10'h001);
      tests++; if (bus_m.rx_valid !== 1'b0) begin fails++; $display("FAIL par_not_yet: got %b want 0", bus_m.rx_valid); end
      mosi = 1'b0;
      tick();
      tests++; if ({bus_m.rx_valid, bus_m.par_err, bus_m.rx_data} !== {2'b10, 10'h001}) begin fails++; $display("FAIL par_ok: got %b_%b_%h want 1_0_001", bus_m.rx_valid, bus_m.par_err, bus_m.rx_data); end
      end_frame();
      send_frame(10'h2AA);
      end_frame();
      send_bits(10'h001);
      mosi = 1'b1;
      tick();
      tests++; if ({bus_m.rx_valid, bus_m.par_err, bus_m.busy} !== 3'b011) begin fails++; $display("FAIL par_bad: got %b want 011", {bus_m.rx_valid, bus_m.par_err, bus_m.busy}); end
      tests++; if (bus_m.rx_data !== 10'h2AA) begin fails++; $display("FAIL par_bad_rx_data: got %h want 2aa", bus_m.rx_data); end
      tick();
      tests++; if (bus_m.par_err !== 1'b0) begin fails++; $display("FAIL par_pulse: got %b want 0", bus_m.par_err); end
      end_frame();
   endtask
`endif

   initial begin
      test_reset();
      test_write_addr();
      test_read(8'hC3, 1'b0);
      test_read(8'h01, 1'b1);
      test_timeout();
      test_abort();
      test_reset_mid_tx();
`ifdef SPI_SLAVE_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
